pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Two-entry elastic pipeline register (main register plus skid register)
// with a valid/ready handshake on both sides. Out_Data always comes straight
// from the main register. In_Ready is decoded from state and Flush only, so
// there is no combinational path from Out_Ready back to In_Ready. This keeps
// long ready chains out of the timing path when stages are cascaded. Unused
// entries are held at zero, so an idle stage always presents a zero bubble.
//
// Parameters
//   DATA_W     payload width in bits (1..256)
//   CNT_W      width of the saturating stall-cycle counter (4..32)
//
// Ports
//   Clk        sole clock; all state updates on the rising edge
//   Reset      synchronous, active-high; overrides Flush and both handshakes
//   Flush      synchronous flush; discards every held entry
//   In_Valid   upstream entry present on In_Data
//   In_Ready   stage can accept an entry this cycle
//   In_Data    upstream payload
//   Out_Valid  Out_Data holds a valid entry
//   Out_Ready  downstream accepts Out_Data this cycle
//   Out_Data   payload to the next stage
//   Occupancy  number of held entries (0, 1 or 2)
//   Stall_Cnt  count of cycles with Out_Valid=1 and Out_Ready=0, saturating
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [DATA_W-1:0] In_Data,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [DATA_W-1:0] Out_Data,
  output logic [1:0]        Occupancy,
  output logic [CNT_W-1:0]  Stall_Cnt
);

  // The state encoding is the entry count, so Occupancy is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stateT;

  stateT             state;
  stateT             stateNext;
  logic [DATA_W-1:0] mainReg;
  logic [DATA_W-1:0] mainNext;
  logic [DATA_W-1:0] skidReg;
  logic [DATA_W-1:0] skidNext;
  logic [CNT_W-1:0]  stallCnt;
  logic              accept;
  logic              emit;

  // Output decodes. Each one depends only on registered state (and on Flush
  // for In_Ready).
  assign In_Ready  = (state != TWO) && !Flush;
  assign Out_Valid = (state != EMPTY);
  assign Out_Data  = mainReg;
  assign Occupancy = state;
  assign Stall_Cnt = stallCnt;

  assign accept = In_Valid & In_Ready;
  assign emit   = Out_Valid & Out_Ready;

  // Next-state and register-load logic.
  always_comb begin
    // NOTE: every signal written here gets a default value first. Without
    // those defaults, a path that does not assign a signal would infer a latch.
    stateNext = state;
    mainNext  = mainReg;
    skidNext  = skidReg;

    if (Flush) begin
      // A downstream emit in this cycle still counts as delivered. Everything
      // else the stage holds is dropped.
      stateNext = EMPTY;
      mainNext  = '0;
      skidNext  = '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            stateNext = ONE;
            mainNext  = In_Data;
          end
        end
        ONE: begin
          case ({accept, emit})
            2'b11: mainNext = In_Data;          // pass-through, full rate
            2'b10: begin                        // downstream stalled: park it
              stateNext = TWO;
              skidNext  = In_Data;
            end
            2'b01: begin                        // drained: zero bubble
              stateNext = EMPTY;
              mainNext  = '0;
            end
            default: ;                          // hold
          endcase
        end
        TWO: begin
          // In_Ready is low in TWO, so the only event here is a drain.
          if (emit) begin
            stateNext = ONE;
            mainNext  = skidReg;
            skidNext  = '0;
          end
        end
        default: begin
          // Encoding 2'b11 is unreachable. Recover to a clean empty stage.
          stateNext = EMPTY;
          mainNext  = '0;
          skidNext  = '0;
        end
      endcase
    end
  end

  // State, payload registers and stall counter.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments. All registers then
    // update together from the values they held before the edge.
    if (Reset) begin
      state    <= EMPTY;
      mainReg  <= '0;
      skidReg  <= '0;
      stallCnt <= '0;
    end else begin
      state   <= stateNext;
      mainReg <= mainNext;
      skidReg <= skidNext;
      // The counter saturates instead of wrapping, and Flush leaves it alone.
      if (Out_Valid && !Out_Ready && (stallCnt != {CNT_W{1'b1}})) begin
        stallCnt <= stallCnt + CNT_W'(1);
      end
    end
  end

endmodule
